// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
//   Bundles the instruction/handshake inputs and every datapath strobe driven
//   by control_sequencer. Clock and clear stay plain ports on the modules.
//
//   Optional feature macro: MFHILO_EN (adds the HIout/LOout strobes).
//
//   Signals
//     IR        32    instruction register contents (from datapath)
//     Mem_ready 1     memory read data valid this cycle
//     Stop      1     level-sensitive halt request
//     PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin   fetch strobes
//     Yin, Zin, Zhighout, Zlowout, HIin, LOin                execute strobes
//     HIout, LOout (MFHILO_EN only)                          HI/LO bus drives
//     Rout_sel  NREG  one-hot register drive onto bus
//     Rin_sel   NREG  one-hot register load from bus
//     alu_op    OPW   ALU operation code
//     Run       1     executing
//     Illegal   1     unsupported-opcode pulse
//
//   Modports
//     master : the control unit (consumes IR/handshake, drives strobes)
//     slave  : the datapath side (drives IR/handshake, consumes strobes)
// -----------------------------------------------------------------------------
interface control_sequencer_if #(
  parameter int OPW  = 5,
  parameter int NREG = 16
);
  logic [31:0]     IR;
  logic            Mem_ready;
  logic            Stop;

  logic            PCout;
  logic            PCin;
  logic            IncPC;
  logic            MARin;
  logic            MDRin;
  logic            MDRout;
  logic            Read;
  logic            IRin;

  logic            Yin;
  logic            Zin;
  logic            Zhighout;
  logic            Zlowout;
  logic            HIin;
  logic            LOin;
`ifdef MFHILO_EN
  logic            HIout;
  logic            LOout;
`endif

  logic [NREG-1:0] Rout_sel;
  logic [NREG-1:0] Rin_sel;
  logic [OPW-1:0]  alu_op;
  logic            Run;
  logic            Illegal;

  modport master (
    input  IR, Mem_ready, Stop,
`ifdef MFHILO_EN
    output HIout, LOout,
`endif
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
    output Yin, Zin, Zhighout, Zlowout, HIin, LOin,
    output Rout_sel, Rin_sel, alu_op, Run, Illegal
  );

  modport slave (
    output IR, Mem_ready, Stop,
`ifdef MFHILO_EN
    input  HIout, LOout,
`endif
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
    input  Yin, Zin, Zhighout, Zlowout, HIin, LOin,
    input  Rout_sel, Rin_sel, alu_op, Run, Illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Hardwired control unit for instruction fetch and ALU-class execute
//   (add/sub/and/or/mul/div). One state per clock; every strobe is decoded
//   from the state register (plus the IR register contents, which are a
//   registered datapath value and stable from T3 on).
//
//   Optional feature macro: MFHILO_EN
//     defined   : mfhi (11000) / mflo (11001) supported, HIout/LOout present
//     undefined : those opcodes take the illegal path
//
//   Ports
//     Clock  in  system clock, posedge
//     clear  in  asynchronous reset, active-low
//     bus    control_sequencer_if.master (IR, Mem_ready, Stop in; strobes out)
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic                 Clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_HALT  = 4'd8;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
`ifdef MFHILO_EN
  localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11001);
`endif

  logic [3:0] state_q, state_d;
  logic       stop_pend_q, stop_pend_d;

  // Instruction field decode
  logic [OPW-1:0]  op;
  logic [3:0]      ra, rb, rc;
  logic [NREG-1:0] ra_sel, rb_sel, rc_sel;
  logic            is_alu2, is_muldiv, is_mf, is_legal, halt_req;
  logic            ir_unused;

  assign op        = bus.IR[31 -: OPW];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign ir_unused = ^bus.IR[14:0];
  assign ra_sel    = NREG'(1) << ra;
  assign rb_sel    = NREG'(1) << rb;
  assign rc_sel    = NREG'(1) << rc;

  assign is_alu2   = (op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_AND) || (op == OP_OR);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
`ifdef MFHILO_EN
  assign is_mf     = (op == OP_MFHI) || (op == OP_MFLO);
`else
  assign is_mf     = 1'b0;
`endif
  assign is_legal  = is_alu2 || is_muldiv || is_mf;

  // A Stop seen in the same cycle as the instruction boundary still counts.
  assign halt_req  = stop_pend_q | bus.Stop;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    if (state_q != S_RESET) begin
      stop_pend_d = stop_pend_q | bus.Stop;
    end
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = bus.Mem_ready ? S_T2 : S_T1;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (!is_legal || is_mf) begin
          state_d = halt_req ? S_HALT : S_T0;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4:    state_d = S_T5;
      S_T5: begin
        if (is_muldiv) begin
          state_d = S_T6;
        end else begin
          state_d = halt_req ? S_HALT : S_T0;
        end
      end
      S_T6:    state_d = halt_req ? S_HALT : S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // State register
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q     <= S_RESET;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Output decode
  logic            pcout, pcin, incpc, marin, mdrin, mdrout, rd, irin;
  logic            yin, zin, zhighout, zlowout, hiin, loin, hiout, loout;
  logic [NREG-1:0] rout_sel, rin_sel;
  logic [OPW-1:0]  alu_op;
  logic            run, illegal;

  always_comb begin
    pcout    = 1'b0;
    pcin     = 1'b0;
    incpc    = 1'b0;
    marin    = 1'b0;
    mdrin    = 1'b0;
    mdrout   = 1'b0;
    rd       = 1'b0;
    irin     = 1'b0;
    yin      = 1'b0;
    zin      = 1'b0;
    zhighout = 1'b0;
    zlowout  = 1'b0;
    hiin     = 1'b0;
    loin     = 1'b0;
    hiout    = 1'b0;
    loout    = 1'b0;
    rout_sel = '0;
    rin_sel  = '0;
    alu_op   = '0;
    run      = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_T0: begin
        run   = 1'b1;
        pcout = 1'b1;
        marin = 1'b1;
        pcin  = 1'b1;
        incpc = 1'b1;
      end
      S_T1: begin
        run   = 1'b1;
        rd    = 1'b1;
        mdrin = 1'b1;
      end
      S_T2: begin
        run    = 1'b1;
        mdrout = 1'b1;
        irin   = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (!is_legal) begin
          illegal = 1'b1;
        end else if (is_mf) begin
          // mfhi/mflo: HI or LO straight onto the bus into Ra.
          hiout   = (op[0] == 1'b0);
          loout   = (op[0] == 1'b1);
          rin_sel = ra_sel;
        end else begin
          rout_sel = rb_sel;
          yin      = 1'b1;
        end
      end
      S_T4: begin
        run      = 1'b1;
        rout_sel = rc_sel;
        alu_op   = op;
        zin      = 1'b1;
      end
      S_T5: begin
        run     = 1'b1;
        zlowout = 1'b1;
        if (is_muldiv) begin
          loin = 1'b1;
        end else begin
          rin_sel = ra_sel;
        end
      end
      S_T6: begin
        run      = 1'b1;
        zhighout = 1'b1;
        hiin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PCout    = pcout;
  assign bus.PCin     = pcin;
  assign bus.IncPC    = incpc;
  assign bus.MARin    = marin;
  assign bus.MDRin    = mdrin;
  assign bus.MDRout   = mdrout;
  assign bus.Read     = rd;
  assign bus.IRin     = irin;
  assign bus.Yin      = yin;
  assign bus.Zin      = zin;
  assign bus.Zhighout = zhighout;
  assign bus.Zlowout  = zlowout;
  assign bus.HIin     = hiin;
  assign bus.LOin     = loin;
  assign bus.Rout_sel = rout_sel;
  assign bus.Rin_sel  = rin_sel;
  assign bus.alu_op   = alu_op;
  assign bus.Run      = run;
  assign bus.Illegal  = illegal;
`ifdef MFHILO_EN
  assign bus.HIout    = hiout;
  assign bus.LOout    = loout;
`else
  logic mf_unused;
  assign mf_unused = hiout | loout;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//   Scoreboard bench: the driver expands each instruction into its expected
//   per-cycle strobe pattern and queues it as the cycle is issued; a monitor
//   on the falling edge pops and compares against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  typedef struct packed {
    logic        pcout, pcin, incpc, marin, mdrin, mdrout, read, irin;
    logic        yin, zin, zhighout, zlowout, hiin, loin, hiout, loout;
    logic        run, illegal;
    logic [15:0] rout, rin;
    logic [4:0]  aluop;
  } ov_t;

  logic clk;
  logic clear;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  ov_t  exp_q[$];

  control_sequencer_if #(.OPW(5), .NREG(16)) bus ();
  control_sequencer #(.OPW(5), .NREG(16)) dut (
    .Clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ov_t sample();
    ov_t r;
    r          = '0;
    r.pcout    = bus.PCout;
    r.pcin     = bus.PCin;
    r.incpc    = bus.IncPC;
    r.marin    = bus.MARin;
    r.mdrin    = bus.MDRin;
    r.mdrout   = bus.MDRout;
    r.read     = bus.Read;
    r.irin     = bus.IRin;
    r.yin      = bus.Yin;
    r.zin      = bus.Zin;
    r.zhighout = bus.Zhighout;
    r.zlowout  = bus.Zlowout;
    r.hiin     = bus.HIin;
    r.loin     = bus.LOin;
`ifdef MFHILO_EN
    r.hiout    = bus.HIout;
    r.loout    = bus.LOout;
`endif
    r.run      = bus.Run;
    r.illegal  = bus.Illegal;
    r.rout     = bus.Rout_sel;
    r.rin      = bus.Rin_sel;
    r.aluop    = bus.alu_op;
    return r;
  endfunction

  // Monitor: compare against the scoreboard and check bus-driver exclusivity.
  always @(negedge clk) begin
    ov_t a, e;
    int  drv;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %h, expected %h", cyc, a, e);
      end
      drv = int'(a.pcout) + int'(a.mdrout) + int'(a.zhighout) + int'(a.zlowout)
          + int'(a.hiout) + int'(a.loout) + ((a.rout != 0) ? 1 : 0);
      checks++;
      if (drv > 1 || !$onehot0(a.rout) || !$onehot0(a.rin)) begin
        errors++;
        $display("FAIL bus_exclusive cycle %0d: got drivers=%0d rout=%h rin=%h, expected <=1 one-hot",
                 cyc, drv, a.rout, a.rin);
      end
    end
  end

  // Reference model helpers
  function automatic bit op_legal(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01111, 5'b10000: return 1'b1;
`ifdef MFHILO_EN
      5'b11000, 5'b11001: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit op_mf(input logic [4:0] op);
`ifdef MFHILO_EN
    return (op == 5'b11000) || (op == 5'b11001);
`else
    return (op == 5'b11111) && (op != 5'b11111);
`endif
  endfunction

  function automatic ov_t busy();
    ov_t r;
    r     = '0;
    r.run = 1'b1;
    return r;
  endfunction

  // One clock of stimulus: set inputs for this cycle, queue its expectation.
  task automatic issue(input ov_t e, input int mr, input bit st);
    @(posedge clk);
    #1;
    bus.Mem_ready = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
    bus.Stop      = st;
    exp_q.push_back(e);
  endtask

  task automatic reset_seq(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      clear = 1'b0;
      bus.Stop = 1'b0;
      exp_q.push_back('0);
    end
    @(posedge clk);
    #1;
    clear = 1'b1;
    exp_q.push_back('0);
  endtask

  // Expands one instruction into its cycle pattern and issues it.
  // result: 0 = completed, 1 = completed then halted, 2 = aborted by clear.
  task automatic do_instr(input logic [4:0] op, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [3:0] rc,
                          input int w, input int stop_at, input int abort_at,
                          output int result);
    ov_t r;
    ov_t seq[$];
    int  mq[$];
    bit  stopped;
    r = busy(); r.pcout = 1; r.marin = 1; r.pcin = 1; r.incpc = 1;
    seq.push_back(r); mq.push_back(-1);
    for (int k = 0; k <= w; k++) begin
      r = busy(); r.read = 1; r.mdrin = 1;
      seq.push_back(r); mq.push_back((k == w) ? 1 : 0);
    end
    r = busy(); r.mdrout = 1; r.irin = 1;
    seq.push_back(r); mq.push_back(-1);
    if (!op_legal(op)) begin
      r = busy(); r.illegal = 1;
      seq.push_back(r); mq.push_back(-1);
    end else if (op_mf(op)) begin
      r = busy(); r.rin = 16'(1) << ra;
      if (op[0]) r.loout = 1; else r.hiout = 1;
      seq.push_back(r); mq.push_back(-1);
    end else begin
      r = busy(); r.rout = 16'(1) << rb; r.yin = 1;
      seq.push_back(r); mq.push_back(-1);
      r = busy(); r.rout = 16'(1) << rc; r.aluop = op; r.zin = 1;
      seq.push_back(r); mq.push_back(-1);
      r = busy(); r.zlowout = 1;
      if (op == 5'b01111 || op == 5'b10000) r.loin = 1;
      else r.rin = 16'(1) << ra;
      seq.push_back(r); mq.push_back(-1);
      if (op == 5'b01111 || op == 5'b10000) begin
        r = busy(); r.zhighout = 1; r.hiin = 1;
        seq.push_back(r); mq.push_back(-1);
      end
    end
    stopped = 1'b0;
    for (int i = 0; i < seq.size(); i++) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.IR = {op, ra, rb, rc, 15'($urandom)};
      bus.Mem_ready = (mq[i] < 0) ? 1'($urandom_range(0, 1)) : 1'(mq[i]);
      bus.Stop      = (i == stop_at);
      if (i == stop_at) stopped = 1'b1;
      if (i == abort_at) begin
        exp_q.push_back('0);
        #1;
        clear  = 1'b0;
        result = 2;
        return;
      end
      exp_q.push_back(seq[i]);
    end
    result = stopped ? 1 : 0;
  endtask

  task automatic after_instr(input int result);
    if (result == 1) begin
      for (int i = 0; i < 10; i++) issue('0, -1, 1'($urandom_range(0, 1)));
      reset_seq(2);
    end else if (result == 2) begin
      reset_seq(2);
    end
  endtask

  initial begin
    int res;
    logic [4:0] legal_ops [6];
    logic [4:0] op;
    int stop_at, abort_at;
    legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01111, 5'b10000};
    clear         = 1'b0;
    bus.IR        = '0;
    bus.Mem_ready = 1'b0;
    bus.Stop      = 1'b0;
    reset_seq(2);

    // and R1,R2,R3 (IR=0x28918000), no memory wait
    do_instr(5'b00101, 4'd1, 4'd2, 4'd3, 0, -1, -1, res); after_instr(res);
    // div: Rb=6, Rc=7
    do_instr(5'b10000, 4'd5, 4'd6, 4'd7, 0, -1, -1, res); after_instr(res);
    // memory wait of three cycles
    do_instr(5'b00011, 4'd2, 4'd4, 4'd8, 3, -1, -1, res); after_instr(res);
    // illegal opcode
    do_instr(5'b11111, 4'd1, 4'd1, 4'd1, 1, -1, -1, res); after_instr(res);
    // mfhi/mflo encodings: illegal unless the feature is built in
    do_instr(5'b11000, 4'd9, 4'd0, 4'd0, 0, -1, -1, res); after_instr(res);
    do_instr(5'b11001, 4'd0, 4'd0, 4'd0, 0, -1, -1, res); after_instr(res);
    // Ra=Rb=Rc=0, mul
    do_instr(5'b01111, 4'd0, 4'd0, 4'd0, 2, -1, -1, res); after_instr(res);
    // Stop pulsed in T2 of add -> completes, then HALT for 10 cycles
    do_instr(5'b00011, 4'd15, 4'd14, 4'd13, 0, 2, -1, res); after_instr(res);
    // Stop in T2, then clear mid-T4: aborts and drops the pending stop
    do_instr(5'b00100, 4'd3, 4'd4, 4'd5, 0, 2, 4, res); after_instr(res);
    do_instr(5'b00110, 4'd7, 4'd8, 4'd9, 1, -1, -1, res); after_instr(res);
    // Stop in the final cycle of div still halts
    do_instr(5'b10000, 4'd1, 4'd2, 4'd3, 0, 6, -1, res); after_instr(res);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 5)];
      else op = 5'($urandom);
      stop_at  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : -1;
      abort_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 8)) : -1;
      do_instr(op, 4'($urandom), 4'($urandom), 4'($urandom),
               int'($urandom_range(0, 4)), stop_at, abort_at, res);
      after_instr(res);
    end

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(negedge clk);
        #1;
        budget++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
